// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: one pipeline stage with valid/ready on both sides,
// plus an optional accumulator that can stand in for operand A.
module logic_unit_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic [WIDTH-1:0]   y,
  output logic               y_zero,
  output logic               y_ones,
  output logic               y_parity,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   acc,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_NOTB = 3'd7
  } op_e;

  logic [WIDTH-1:0]   y_q, y_d;
  logic               y_zero_q, y_zero_d;
  logic               y_ones_q, y_ones_d;
  logic               y_parity_q, y_parity_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   result;

  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    op_a     = acc_en ? acc_q : a;
    result   = '0;
    case (op_e'(op))
      OP_AND:  result = op_a & b;
      OP_OR:   result = op_a | b;
      OP_NAND: result = ~(op_a & b);
      OP_NOR:  result = ~(op_a | b);
      OP_XOR:  result = op_a ^ b;
      OP_XNOR: result = ~(op_a ^ b);
      OP_NOTA: result = ~op_a;
      OP_NOTB: result = ~b;
      default: result = '0;
    endcase
  end

  always_comb begin
    y_d         = y_q;
    y_zero_d    = y_zero_q;
    y_ones_d    = y_ones_q;
    y_parity_d  = y_parity_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    acc_d       = acc_q;

    if (accept) begin
      y_d         = result;
      y_zero_d    = (result == '0);
      y_ones_d    = &result;
      y_parity_d  = ^result;
      out_valid_d = 1'b1;
      op_count_d  = op_count_q + COUNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over the accumulate write-back; the accepted op still saw the old acc.
    if (acc_clr) begin
      acc_d = '0;
    end else if (accept && acc_en) begin
      acc_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      y_zero_q    <= 1'b0;
      y_ones_q    <= 1'b0;
      y_parity_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      y_q         <= y_d;
      y_zero_q    <= y_zero_d;
      y_ones_q    <= y_ones_d;
      y_parity_q  <= y_parity_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign y         = y_q;
  assign y_zero    = y_zero_q;
  assign y_ones    = y_ones_q;
  assign y_parity  = y_parity_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: an 8-bit unit driven with directed vectors, and a
// 1-bit unit with a 2-bit counter for the narrow-width and counter-wrap cases.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid, in_ready, acc_en, acc_clr, out_valid, out_ready;
  logic [7:0] a, b, y, acc, op_count;
  logic [2:0] op;
  logic       y_zero, y_ones, y_parity;

  logic       w_in_valid, w_in_ready, w_acc_en, w_acc_clr, w_out_valid, w_out_ready;
  logic [0:0] w_a, w_b, w_y, w_acc;
  logic [2:0] w_op;
  logic [1:0] w_op_count;
  logic       w_y_zero, w_y_ones, w_y_parity;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .y(y), .y_zero(y_zero), .y_ones(y_ones), .y_parity(y_parity),
    .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(1), .COUNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .acc_en(w_acc_en), .acc_clr(w_acc_clr),
    .y(w_y), .y_zero(w_y_zero), .y_ones(w_y_ones), .y_parity(w_y_parity),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .acc(w_acc), .op_count(w_op_count)
  );

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  bit   acc_pulse = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every beat the consumer takes is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (acc_pulse) begin
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        acc_pulse = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("y", {24'd0, y}, {24'd0, e.y});
          check("y_zero", {31'd0, y_zero}, {31'd0, e.z});
          check("y_ones", {31'd0, y_ones}, {31'd0, e.o});
          check("y_parity", {31'd0, y_parity}, {31'd0, e.p});
        end
      end
    end
  end

  task automatic send(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] opi,
                      input logic ae, input logic ac, input logic [7:0] ey);
    logic rdy;
    bit   done;
    done     = 1'b0;
    a        = ai;
    b        = bi;
    op       = opi;
    acc_en   = ae;
    acc_clr  = ac;
    in_valid = 1'b1;
    for (int unsigned n = 0; n < 16 && !done; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        sb.push_back('{ey, (ey == 8'h00), &ey, ^ey});
        acc_pulse = 1'b1;
        done      = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd1, 32'd0);
    #1;
    acc_clr = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    acc_en   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] t1_exp [8];
  logic       wv_a [5];
  logic       wv_b [5];
  logic [2:0] wv_op [5];
  logic       wv_y [5];

  initial begin
    t1_exp = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'h33};
    wv_a   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    wv_b   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    wv_op  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd7};
    wv_y   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op = '0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_op = '0; w_acc_en = 1'b0; w_acc_clr = 1'b0;
    w_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_flags", {29'd0, y_zero, y_ones, y_parity}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_op_count", {24'd0, op_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    idle(1);

    // All eight ops back to back on a=F0, b=CC.
    for (int unsigned i = 0; i < 8; i++) send(8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0, t1_exp[i]);
    idle(2);
    check("op_count_after_8", {24'd0, op_count}, 32'd8);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_y_hold", {24'd0, y}, 32'h33);

    // Flag corner values.
    send(8'h5A, 8'h5A, 3'd4, 1'b0, 1'b0, 8'h00);
    send(8'h00, 8'h00, 3'd3, 1'b0, 1'b0, 8'hFF);
    idle(2);

    // Stall: result must hold while the consumer is not ready.
    out_ready = 1'b0;
    send(8'hFF, 8'h81, 3'd0, 1'b0, 1'b0, 8'h81);
    a = 8'h00; b = 8'h00; op = 3'd1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_y", {24'd0, y}, 32'h81);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_op_count", {24'd0, op_count}, 32'd11);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h00, 8'hFF, 3'd1, 1'b0, 1'b0, 8'hFF);
    check("release_op_count", {24'd0, op_count}, 32'd12);
    idle(2);

    // Accumulate chain and clear priority.
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc_clr", {24'd0, acc}, 32'd0);
    send(8'hFF, 8'h01, 3'd1, 1'b1, 1'b0, 8'h01);
    check("acc_01", {24'd0, acc}, 32'h01);
    send(8'hFF, 8'h02, 3'd1, 1'b1, 1'b0, 8'h03);
    check("acc_03", {24'd0, acc}, 32'h03);
    send(8'hFF, 8'h04, 3'd1, 1'b1, 1'b0, 8'h07);
    check("acc_07", {24'd0, acc}, 32'h07);
    send(8'hFF, 8'h07, 3'd4, 1'b1, 1'b0, 8'h00);
    check("acc_xor_00", {24'd0, acc}, 32'h00);
    send(8'h00, 8'h07, 3'd1, 1'b1, 1'b0, 8'h07);
    check("acc_reload_07", {24'd0, acc}, 32'h07);
    send(8'hFF, 8'h08, 3'd1, 1'b1, 1'b1, 8'h0F);
    check("acc_clr_same_cycle", {24'd0, acc}, 32'h00);
    send(8'hF0, 8'h00, 3'd1, 1'b0, 1'b0, 8'hF0);
    check("acc_hold_no_acc_en", {24'd0, acc}, 32'h00);
    idle(2);

    // Narrow unit: WIDTH=1 results and 2-bit counter wrap.
    for (int unsigned i = 0; i < 5; i++) begin
      w_a = wv_a[i]; w_b = wv_b[i]; w_op = wv_op[i]; w_in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("w_op_count", {30'd0, w_op_count}, 32'((i + 1) % 4));
      check("w_y", {31'd0, w_y}, {31'd0, wv_y[i]});
      check("w_flags", {29'd0, w_y_zero, w_y_ones, w_y_parity},
            {29'd0, !wv_y[i], wv_y[i], wv_y[i]});
    end
    w_out_ready = 1'b0;
    w_a = 1'b1; w_b = 1'b1; w_op = 3'd0;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;

    // Reset in the middle of a stall clears everything without waiting for a clock.
    out_ready = 1'b0;
    send(8'h00, 8'h55, 3'd1, 1'b1, 1'b0, 8'h55);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_acc", {24'd0, acc}, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_y", {24'd0, y}, 32'd0);
    check("async_rst_flags", {29'd0, y_zero, y_ones, y_parity}, 32'd0);
    check("async_rst_acc", {24'd0, acc}, 32'd0);
    check("async_rst_op_count", {24'd0, op_count}, 32'd0);
    check("w_async_rst", {27'd0, w_out_valid, w_y, w_y_zero, w_op_count}, 32'd0);
    sb.delete();
    acc_pulse = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
